// File: rtl/linear_layer_q_start_fifo_shiftreg.sv
// Start-token storage: shift-in at slot 0 on we, combinational read of slot addr.
// One-cycle write latency; no flow control here, the parent gates we.
module linear_layer_q_start_fifo_shiftreg #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_d[i] = mem_q[i-1];
      end
    end
  end

  // Contents are deliberately not reset; occupancy tracking lives in the parent.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  // Addresses beyond DEPTH-1 are unreachable; they read zero.
  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_WIDTH'(i)) begin
        dout = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/linear_layer_q_start_fifo.sv
// FWFT start-token FIFO with full_n/empty_n handshake and occupancy count.
// Write-to-read latency 1 cycle; writes gated by registered full_n, reads by empty_n.
module linear_layer_q_start_fifo #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic [ADDR_WIDTH:0]   if_fifo_cap
);

  localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  empty_n_q, empty_n_d;
  logic                  full_n_q, full_n_d;
  logic                  push, pop;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign push = if_write_ce & if_write & full_n_q;
  assign pop  = if_read_ce & if_read & empty_n_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    empty_n_d = (count_d != '0);
    full_n_d  = (count_d != CNT_DEPTH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
    end else begin
      count_q   <= count_d;
      empty_n_q <= empty_n_d;
      full_n_q  <= full_n_d;
    end
  end

  // Newest token sits in slot 0, so the oldest is at count-1.
  assign rd_addr = count_q[ADDR_WIDTH-1:0] - ADDR_ONE;

  linear_layer_q_start_fifo_shiftreg #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_shiftreg (
    .clk  (clk),
    .we   (push & ~reset),
    .addr (rd_addr),
    .din  (if_din),
    .dout (if_dout)
  );

  assign if_full_n         = full_n_q;
  assign if_empty_n        = empty_n_q;
  assign if_num_data_valid = count_q;
  assign if_fifo_cap       = CNT_DEPTH;

endmodule

// File: tb/tb_linear_layer_q_start_fifo.sv
// Scoreboard bench: stimulus pushes expected tokens, monitor checks flags and pops.
module tb_linear_layer_q_start_fifo;

  localparam int DW = 8;
  localparam int AW = 1;
  localparam int DP = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_full_n, if_empty_n;
  logic          if_write_ce = 1'b0, if_write = 1'b0;
  logic          if_read_ce = 1'b0, if_read = 1'b0;
  logic [DW-1:0] if_din = '0;
  logic [DW-1:0] if_dout;
  logic [AW:0]   if_num_data_valid, if_fifo_cap;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;
  int model_cnt = 0;
  logic [DW-1:0] sb[$];

  always #5 clk = ~clk;

  linear_layer_q_start_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
    .clk               (clk),
    .reset             (reset),
    .if_full_n         (if_full_n),
    .if_write_ce       (if_write_ce),
    .if_write          (if_write),
    .if_din            (if_din),
    .if_empty_n        (if_empty_n),
    .if_read_ce        (if_read_ce),
    .if_read           (if_read),
    .if_dout           (if_dout),
    .if_num_data_valid (if_num_data_valid),
    .if_fifo_cap       (if_fifo_cap)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: flags/count against model occupancy; dout checked on each pop.
  always @(negedge clk) begin
    if (mon_en) begin
      check("count", int'(if_num_data_valid), model_cnt);
      check("empty_n", int'(if_empty_n), int'(model_cnt != 0));
      check("full_n", int'(if_full_n), int'(model_cnt != DP));
      check("fifo_cap", int'(if_fifo_cap), DP);
      if (!reset && if_read_ce && if_read && if_empty_n) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_underflow: DUT popped %0h, scoreboard empty", if_dout);
        end else begin
          check("pop_dout", int'(if_dout), int'(sb.pop_front()));
        end
      end
    end
  end

  // One clock of stimulus, entered and left just after a rising edge.
  task automatic cycle(input bit rst, input bit wce, input bit w, input logic [DW-1:0] d,
                       input bit rce, input bit r);
    bit push_ok, pop_ok;
    reset = rst; if_write_ce = wce; if_write = w; if_din = d;
    if_read_ce = rce; if_read = r;
    push_ok = !rst && wce && w && (model_cnt != DP);
    pop_ok  = !rst && rce && r && (model_cnt != 0);
    if (push_ok) sb.push_back(d);
    @(posedge clk);
    if (rst) begin
      model_cnt = 0;
      sb.delete();
    end else begin
      model_cnt = model_cnt + int'(push_ok) - int'(pop_ok);
    end
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d); cycle(0, 1, 1, d, 0, 0); endtask
  task automatic rd();                       cycle(0, 0, 0, 8'h00, 1, 1); endtask
  task automatic idle();                     cycle(0, 0, 0, 8'h00, 0, 0); endtask

  initial begin
    @(posedge clk); #1;
    // Reset with a write held high: nothing may be stored.
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 8'h55, 0, 0);
    mon_en = 1'b1;
    idle();

    // Fill, then an ignored third write.
    wr(8'h11);
    check("fill_dout0", int'(if_dout), 8'h11);
    wr(8'h22);
    wr(8'h33);
    check("full_dout_hold", int'(if_dout), 8'h11);
    check("full_count", int'(if_num_data_valid), 2);

    // Drain plus extra reads.
    rd();
    check("drain_dout1", int'(if_dout), 8'h22);
    rd(); rd(); rd();

    // Streaming at count 1.
    wr(8'hA0);
    for (int i = 1; i <= 3; i++) begin
      cycle(0, 1, 1, 8'hA0 + 8'(i), 1, 1);
      check("stream_dout", int'(if_dout), 8'hA0 + i);
    end
    rd();

    // Full with write and read: only the pop happens.
    wr(8'h01); wr(8'h02);
    cycle(0, 1, 1, 8'h99, 1, 1);
    check("fullwr_dout", int'(if_dout), 8'h02);
    wr(8'h77);
    rd(); rd();

    // Empty with write and read: only the push happens.
    cycle(0, 1, 1, 8'h5A, 1, 1);
    check("emptywr_dout", int'(if_dout), 8'h5A);
    rd();

    // Clock-enable gating, then reset while full.
    cycle(0, 0, 1, 8'h44, 0, 1);
    wr(8'hC1); wr(8'hC2);
    cycle(0, 1, 1, 8'hC3, 0, 1);
    cycle(1, 1, 1, 8'hEE, 1, 1);
    idle();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 99) == 0), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end
    idle();
    check("final_sb_size", sb.size(), model_cnt);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/linear_layer_q_start_fifo.md
# linear_layer_q_start_fifo

Start-token FIFO controller between two dataflow processes of the i4xi4 linear layer. It buffers up to DEPTH start tokens from the producer's start/done side, so the producer can run ahead of the consumer PE by DEPTH invocations. It wraps an SRL-style storage sub-module with the standard full_n/empty_n handshake and provides first-word-fall-through reads and an occupancy count.

## Interface
- DATA_WIDTH, 1: token width in bits.
- ADDR_WIDTH, 1: storage address width. Must satisfy 2^ADDR_WIDTH >= DEPTH.
- DEPTH, 2: capacity in tokens. Must be >= 1.
- clk  in  1  single clock. All state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_full_n  out  1  high = a write will be accepted this cycle.
- if_write_ce  in  1  write clock-enable.
- if_write  in  1  write request.
- if_din  in  DATA_WIDTH  write data.
- if_empty_n  out  1  high = if_dout holds a valid token.
- if_read_ce  in  1  read clock-enable.
- if_read  in  1  read request / pop.
- if_dout  out  DATA_WIDTH  oldest token (FWFT).
- if_num_data_valid  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- if_fifo_cap  out  ADDR_WIDTH+1  constant DEPTH.

## Operation
- push = if_write_ce & if_write & if_full_n. pop = if_read_ce & if_read & if_empty_n.
- Requests while gated (full or empty) are ignored. No error flag.
- Storage is a shift register. On push, din enters slot 0 and all entries shift up by one. The read address is count-1, so the oldest token is always addressed.
- Occupancy count update:
  - push only: count+1.
  - pop only: count-1.
  - push & pop together: unchanged. Data shifts and the address is held, so if_dout advances to the next-oldest token.
  - neither: hold.
- Flags are registered and derived from the next count value:
  - if_empty_n <= (next_count != 0).
  - if_full_n <= (next_count != DEPTH).
- Arithmetic: count is ADDR_WIDTH+1 bits and never wraps. By construction it stays within 0..DEPTH.
- Read address = count-1 truncated to ADDR_WIDTH bits. When count==0 the address is a don't-care and if_dout is undefined.
- Reset values: count=0, if_empty_n=0, if_full_n=1, if_num_data_valid=0. Storage contents are not cleared.
- Reset mid-operation discards all tokens. Any push or pop in the reset cycle is ignored.
- Boundary cases:
  - Full with write and read asserted: only the pop occurs (full_n=0 gates the push). Count becomes DEPTH-1 and if_full_n rises the next cycle.
  - Empty with write and read asserted: only the push occurs. Count becomes 1.
  - DEPTH=1: if_full_n and if_empty_n are complementary at all times.

## Timing
- Write-to-read latency is 1 cycle. A push at edge t gives if_empty_n=1 and valid if_dout after edge t.
- if_dout is combinational from the storage and count registers. It has no input-to-output combinational path.
- if_full_n, if_empty_n and if_num_data_valid are all registered.
- Sustained throughput is 1 token/cycle whenever the FIFO is neither full nor empty, including simultaneous push/pop.
- A full FIFO accepts a new write on the cycle after a pop.

## Structure
- No shared package. All widths derive from the module parameters.
- One sub-module, linear_layer_q_start_fifo_shiftreg, with parameters DATA_WIDTH, ADDR_WIDTH and DEPTH and ports clk, we, addr, din, dout.
  - we = push.
  - On we, din enters slot 0 and the other entries shift up by one.
  - dout = storage[addr], combinational.
- The parent holds the count, the flags and the push/pop gating.

## Test plan
All scenarios use DATA_WIDTH=8, DEPTH=2.
- Reset: hold reset 3 cycles → empty_n=0, full_n=1, num_data_valid=0. A write during reset is not stored.
- Fill: push 0x11 then 0x22 → after the first edge empty_n=1, dout=0x11. After the second edge full_n=0, count=2. A third write of 0x33 is ignored and dout stays 0x11.
- Drain: from full, pop twice → dout goes 0x11, then 0x22, then empty_n=0 with count=0. Extra reads leave count at 0.
- Streaming:
  - Setup: count=1, holding 0xA0.
  - Stimulus: push and pop every cycle with din 0xA1, 0xA2, 0xA3.
  - Response: dout sequence 0xA0, 0xA1, 0xA2, 0xA3. Count stays 1 and empty_n stays 1.
- Full with write and read: count stays 2? No → count goes to 1 and the write data is lost. Next cycle full_n=1 and a write is accepted.
- Clock-enable gating and mid-run reset:
  - if_write=1 with if_write_ce=0 → no push.
  - Assert reset while count=2 → next cycle count=0, empty_n=0, full_n=1.
